// File: rtl/icache_refill_controller_if.sv
// Bundles the fetch, array and instruction-memory signals of the I-cache
// refill controller. The controller uses the master view; the
// fetch/array/memory side uses the slave view.
interface icache_refill_controller_if #(
   parameter int CNT_W = 16
);
   // fetch stage and cache array lookup
   logic              cpu_req;
   logic [31:0]       cpu_addr;
   logic              cache_hit;
   logic              flush;
   logic              cpu_stall;
   // instruction memory burst port
   logic              mem_req;
   logic [31:0]       mem_addr;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   // cache array update port
   logic              fill_valid;
   logic [2:0]        fill_index;
   logic [24:0]       fill_tag;
   logic [127:0]      fill_line;
   logic              inval_valid;
   logic [2:0]        inval_index;
   // status
   logic              bus_err;
   logic [CNT_W-1:0]  miss_count;

   modport master (
      input  cpu_req, cpu_addr, cache_hit, flush, mem_ready, mem_rdata,
      output cpu_stall, mem_req, mem_addr, fill_valid, fill_index, fill_tag,
             fill_line, inval_valid, inval_index, bus_err, miss_count
   );

   modport slave (
      output cpu_req, cpu_addr, cache_hit, flush, mem_ready, mem_rdata,
      input  cpu_stall, mem_req, mem_addr, fill_valid, fill_index, fill_tag,
             fill_line, inval_valid, inval_index, bus_err, miss_count
   );
endinterface

// File: rtl/icache_refill_controller.sv
// Miss sequencer for the 8-line x 4-word direct-mapped I-cache.
// Stalls fetch on a miss, bursts the four words of the line from memory,
// writes the assembled line into the array, sequences whole-cache
// invalidation and aborts bursts that stall too long.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a lookup miss or a flush request
// S_BURST | reading beats 0..3 of the missing line from memory
// S_FILL  | one-cycle write of the assembled line into the array
// S_DONE  | one cycle for the array update to become visible
// S_FLUSH | invalidating lines 0..7, one per cycle
module icache_refill_controller #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   icache_refill_controller_if.master bus
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // the cycle in which the idle count would reach TIMEOUT
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BURST,
      S_FILL,
      S_DONE,
      S_FLUSH
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [31:4]        miss_line;
   logic [1:0]         beat;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               flush_pend;
   logic [127:0]       buffer;
   logic [CNT_W-1:0]   miss_count;
   logic [2:0]         inval_cnt;

   logic               miss_start;
   logic               beat_acc;
   logic               burst_timeout;

   logic               mem_req;
   logic [31:0]        mem_addr;
   logic               fill_valid;
   logic               inval_valid;
   logic [2:0]         inval_index;
   logic               bus_err;

   // byte-offset bits of the fetch address play no part in a line refill
   logic               unused_addr_bits;
   assign unused_addr_bits = ^bus.cpu_addr[3:0];

   assign miss_start    = (state == S_IDLE) && (state_nxt == S_BURST);
   assign beat_acc      = (state == S_BURST) && bus.mem_ready;
   assign burst_timeout = (state == S_BURST) && !bus.mem_ready &&
                          (wait_cnt == WAIT_LAST);

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and state-decoded outputs
   always_comb begin
      state_nxt   = state;
      mem_req     = 1'b0;
      mem_addr    = 32'd0;
      fill_valid  = 1'b0;
      inval_valid = 1'b0;
      inval_index = 3'd0;
      bus_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.flush || flush_pend) begin
               state_nxt = S_FLUSH;
            end else if (bus.cpu_req && !bus.cache_hit) begin
               state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            mem_req  = 1'b1;
            mem_addr = {miss_line, beat, 2'b00};
            if (bus.mem_ready) begin
               if (beat == 2'd3) begin
                  state_nxt = S_FILL;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               bus_err   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_FILL: begin
            fill_valid = 1'b1;
            state_nxt  = S_DONE;
         end
         S_DONE: begin
            state_nxt = (flush_pend || bus.flush) ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            inval_valid = 1'b1;
            inval_index = inval_cnt;
            if (inval_cnt == 3'd7) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // miss capture, beat and idle-cycle counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         miss_line <= '0;
         beat      <= 2'd0;
         wait_cnt  <= '0;
      end else if (miss_start) begin
         miss_line <= bus.cpu_addr[31:4];
         beat      <= 2'd0;
         wait_cnt  <= '0;
      end else if (beat_acc) begin
         beat      <= beat + 2'd1;
         wait_cnt  <= '0;
      end else if ((state == S_BURST) && !burst_timeout) begin
         wait_cnt  <= wait_cnt + WAIT_W'(1);
      end
   end

   // line assembly buffer; cleared on timeout so no stale beats survive
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buffer <= '0;
      end else if (beat_acc) begin
         buffer[{beat, 5'd0} +: 32] <= bus.mem_rdata;
      end else if (burst_timeout) begin
         buffer <= '0;
      end
   end

   // saturating count of refills started
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         miss_count <= '0;
      end else if (miss_start && (miss_count != '1)) begin
         miss_count <= miss_count + CNT_W'(1);
      end
   end

   // flush requests during a refill are remembered until the sweep finishes
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flush_pend <= 1'b0;
      end else if ((state == S_FLUSH) && (inval_cnt == 3'd7)) begin
         flush_pend <= 1'b0;
      end else if (bus.flush && ((state == S_BURST) || (state == S_FILL) ||
                                 (state == S_DONE))) begin
         flush_pend <= 1'b1;
      end
   end

   // invalidation sweep index
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inval_cnt <= 3'd0;
      end else if (state == S_FLUSH) begin
         inval_cnt <= inval_cnt + 3'd1;
      end else begin
         inval_cnt <= 3'd0;
      end
   end

   assign bus.cpu_stall   = (state != S_IDLE) ||
                            (bus.cpu_req && !bus.cache_hit) ||
                            ((state == S_IDLE) && bus.flush);
   assign bus.mem_req     = mem_req;
   assign bus.mem_addr    = mem_addr;
   assign bus.fill_valid  = fill_valid;
   assign bus.fill_index  = miss_line[6:4];
   assign bus.fill_tag    = miss_line[31:7];
   assign bus.fill_line   = buffer;
   assign bus.inval_valid = inval_valid;
   assign bus.inval_index = inval_index;
   assign bus.bus_err     = bus_err;
   assign bus.miss_count  = miss_count;

endmodule
